ar_arbiter: RTL
===============

// Module: ar_arbiter
// PURPOSE
//  Read-address (AR) stage of the AXI interconnect, directly upstream of the read-data router.
//  - Arbitrates AR requests from masters M0/M1/M2 and decodes ARADDR to S0/S1/S2/S5 or the default (DECERR) slave.
//  - Forwards the request with the master index prepended to ARID, so the R router can steer responses back.
//  - Enforces one outstanding read per slave; the R router's finish_Sx pulses free a slave.
// PARAMETERS
//  ID_BITS    4   master-side ID width (`AXI_ID_BITS); slave-side ID = ID_BITS+4 (`AXI_IDS_BITS)
//  ADDR_BITS  32  address width (`AXI_ADDR_BITS)
// PORTS
//  clk                 in   1          clock, rising edge
//  rst                 in   1          asynchronous reset, active-low
//  ARID_M{0,1,2}       in   ID_BITS    per-master ID
//  ARADDR_M{0,1,2}     in   ADDR_BITS  per-master address
//  ARLEN_M{0,1,2}      in   4          burst length-1
//  ARSIZE_M{0,1,2}     in   3          beat size
//  ARBURST_M{0,1,2}    in   2          burst type
//  ARVALID_M{0,1,2}    in   1          request valid
//  ARREADY_M{0,1,2}    out  1          request accepted
//  ARID_S{0,1,2,5}     out  ID_BITS+4  {2'b0, master idx[1:0], ARID}
//  ARADDR/ARLEN/ARSIZE/ARBURST_S{0,1,2,5}  out  as master  forwarded fields
//  ARVALID_S{0,1,2,5}  out  1          request valid to slave
//  ARREADY_S{0,1,2,5}  in   1          slave accepts
//  finish_S{0,1,2,5}   in   1          from R router: last beat of slave's burst done
//  getaddr_default     out  1          1-cycle pulse: an AR to the default slave was accepted
//  master_signal       out  1          valid with getaddr_default: 1 = requester was M1, 0 = M0
// BEHAVIOUR
//  Reset values: all outputs 0; state=IDLE; rr_ptr=M0; busy[S0,S1,S2,S5]=0.
//  Decode (comb., from the granted master's ARADDR):
//   - S0 0x0000_0000-0x0000_3FFF
//   - S1 0x0001_0000-0x0001_FFFF
//   - S2 0x0002_0000-0x0002_FFFF
//   - S5 0x2000_0000-0x201F_FFFF
//   - anything else -> DEFAULT
//  FSM (registered):
//   - IDLE: when any ARVALID_Mx, grant the first valid master in round-robin order starting at rr_ptr,
//     latch grant, go to BUSY. No ARREADY_Mx is asserted in IDLE.
//   - BUSY, target Sx with busy[x]=0: ARVALID_Sx=1; all AR fields driven from the granted master;
//     ARREADY_Mg=ARREADY_Sx. On handshake: busy[x]<=1, rr_ptr<=g+1 (mod 3), go to IDLE.
//   - BUSY, target Sx with busy[x]=1: ARVALID_Sx=0; hold in BUSY (no re-arbitration) until busy clears.
//   - BUSY, target DEFAULT: ARREADY_Mg=1 the same cycle, getaddr_default=1, master_signal=(g==M1);
//     update rr_ptr, go to IDLE. An M2 request to the default slave reports master_signal=0.
//  Latency: ARVALID_M in cycle 0 -> earliest ARVALID_S/ARREADY_M in cycle 1; min 2 cycles between grants.
//  busy update: busy[x] <= (busy[x] & ~finish_Sx) | accept_x. The BUSY check uses registered busy, so
//   finish_Sx and a pending request to Sx in the same cycle -> ARVALID_Sx rises the next cycle.
//  ARVALID_Sx stays high and all fields stay stable until ARREADY_Sx, regardless of other masters' valids.
//  Unselected slave ports drive all-zero fields. Only one ARVALID_S* is high at any time.
//  Reset mid-transfer: all state, busy flags and outputs return to reset values immediately (async).
// STRUCTURE
//  Shared package axi_ic_pkg:
//   - slave-select enum {SEL_S0,SEL_S1,SEL_S2,SEL_S5,SEL_DEF}
//   - address-map base/limit localparams
//   - master-index constants
//  Also reused by the write-address stage.
//  Sub-module ar_addr_decoder: combinational, ARADDR -> slave-select enum. The rest is flat.
// TESTING
//  1. M1 ARVALID, ARADDR=0x0001_0040, ARID=4'h3, S1 ready -> cycle 1: ARVALID_S1=1, ARID_S1=8'h13, ARREADY_M1=1.
//  2. M0,M1,M2 all valid to S2 (distinct addrs), finish_S2 pulsed after each accept -> grant order M0,M1,M2.
//  3. M0 AR to S0 accepted; M1 AR to S0 with finish_S0 low 5 cycles -> ARVALID_S0 stays 0; rises the cycle after finish_S0.
//  4. M1 ARADDR=0x1000_0000 -> getaddr_default=1, master_signal=1 for exactly one cycle; no ARVALID_S*.
//  5. ARREADY_S5 low 3 cycles for M2 ARADDR=0x2000_0010 -> fields stable and ARVALID_S5 held until handshake.
//  6. rst low while BUSY with ARVALID_S0=1 -> all outputs 0 at once; after release, the first request is served normally.

Source files
------------

// File: rtl/axi_ic_pkg.sv
// Shared AXI interconnect definitions: slave-select codes, address map and master indices.
// Used by both the read-address and write-address stages.
package axi_ic_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned NUM_MST    = 3;

  typedef enum logic [2:0] {
    SEL_S0  = 3'd0,
    SEL_S1  = 3'd1,
    SEL_S2  = 3'd2,
    SEL_S5  = 3'd3,
    SEL_DEF = 3'd4
  } slv_sel_e;

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  localparam logic [AXI_ADDR_W-1:0] S0_BASE  = 32'h0000_0000;
  localparam logic [AXI_ADDR_W-1:0] S0_LIMIT = 32'h0000_3FFF;
  localparam logic [AXI_ADDR_W-1:0] S1_BASE  = 32'h0001_0000;
  localparam logic [AXI_ADDR_W-1:0] S1_LIMIT = 32'h0001_FFFF;
  localparam logic [AXI_ADDR_W-1:0] S2_BASE  = 32'h0002_0000;
  localparam logic [AXI_ADDR_W-1:0] S2_LIMIT = 32'h0002_FFFF;
  localparam logic [AXI_ADDR_W-1:0] S5_BASE  = 32'h2000_0000;
  localparam logic [AXI_ADDR_W-1:0] S5_LIMIT = 32'h201F_FFFF;

  localparam logic [1:0] MST_M0 = 2'd0;
  localparam logic [1:0] MST_M1 = 2'd1;
  localparam logic [1:0] MST_M2 = 2'd2;

  // Regions are power-of-two sized and aligned, so a masked compare covers base..limit.
  function automatic logic addr_hit(input logic [AXI_ADDR_W-1:0] addr,
                                    input logic [AXI_ADDR_W-1:0] base,
                                    input logic [AXI_ADDR_W-1:0] limit);
    return (addr & ~(limit - base)) == base;
  endfunction

  function automatic logic [1:0] mst_inc(input logic [1:0] m);
    return (m == MST_M2) ? MST_M0 : (m + 2'd1);
  endfunction

  function automatic logic [1:0] sel_slot(input slv_sel_e s);
    logic [1:0] slot;
    case (s)
      SEL_S0:  slot = 2'd0;
      SEL_S1:  slot = 2'd1;
      SEL_S2:  slot = 2'd2;
      SEL_S5:  slot = 2'd3;
      default: slot = 2'd0;
    endcase
    return slot;
  endfunction

endpackage

// File: rtl/ar_addr_decoder.sv
// Combinational address decoder: maps an AR address onto the slave-select code.
module ar_addr_decoder
  import axi_ic_pkg::*;
(
  input  logic [AXI_ADDR_W-1:0] addr_i,
  output slv_sel_e              sel_o
);

  // Address map lookup; anything unmapped goes to the DECERR slave
  always_comb begin
    if (addr_hit(addr_i, S0_BASE, S0_LIMIT)) begin
      sel_o = SEL_S0;
    end else if (addr_hit(addr_i, S1_BASE, S1_LIMIT)) begin
      sel_o = SEL_S1;
    end else if (addr_hit(addr_i, S2_BASE, S2_LIMIT)) begin
      sel_o = SEL_S2;
    end else if (addr_hit(addr_i, S5_BASE, S5_LIMIT)) begin
      sel_o = SEL_S5;
    end else begin
      sel_o = SEL_DEF;
    end
  end

endmodule

// File: rtl/ar_arbiter.sv
// AXI read-address stage: round-robin arbitration of M0..M2, decode to S0/S1/S2/S5/DEFAULT,
// master index prepended to ARID, and one outstanding read per slave.
module ar_arbiter
  import axi_ic_pkg::*;
#(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ID_BITS-1:0]   ARID_M0, ARID_M1, ARID_M2,
  input  logic [ADDR_BITS-1:0] ARADDR_M0, ARADDR_M1, ARADDR_M2,
  input  logic [3:0]           ARLEN_M0, ARLEN_M1, ARLEN_M2,
  input  logic [2:0]           ARSIZE_M0, ARSIZE_M1, ARSIZE_M2,
  input  logic [1:0]           ARBURST_M0, ARBURST_M1, ARBURST_M2,
  input  logic                 ARVALID_M0, ARVALID_M1, ARVALID_M2,
  output logic                 ARREADY_M0, ARREADY_M1, ARREADY_M2,
  output logic [ID_BITS+3:0]   ARID_S0, ARID_S1, ARID_S2, ARID_S5,
  output logic [ADDR_BITS-1:0] ARADDR_S0, ARADDR_S1, ARADDR_S2, ARADDR_S5,
  output logic [3:0]           ARLEN_S0, ARLEN_S1, ARLEN_S2, ARLEN_S5,
  output logic [2:0]           ARSIZE_S0, ARSIZE_S1, ARSIZE_S2, ARSIZE_S5,
  output logic [1:0]           ARBURST_S0, ARBURST_S1, ARBURST_S2, ARBURST_S5,
  output logic                 ARVALID_S0, ARVALID_S1, ARVALID_S2, ARVALID_S5,
  input  logic                 ARREADY_S0, ARREADY_S1, ARREADY_S2, ARREADY_S5,
  input  logic                 finish_S0, finish_S1, finish_S2, finish_S5,
  output logic                 getaddr_default,
  output logic                 master_signal
);

  localparam int IDS_BITS = ID_BITS + 4;

  ar_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_q, rr_d;
  logic [3:0] busy_q, busy_d;

  logic [3:0]           mvalid_s, sready_s, finish_s;
  logic [ID_BITS-1:0]   g_id_s;
  logic [ADDR_BITS-1:0] g_addr_s;
  logic [3:0]           g_len_s;
  logic [2:0]           g_size_s;
  logic [1:0]           g_burst_s;
  logic [IDS_BITS-1:0]  fwd_id_s;
  slv_sel_e             sel_s;
  logic [1:0]           slot_s;
  logic [1:0]           pick_s, cand_s;
  logic                 found_s;
  logic [3:0]           slv_vld_s, accept_s;
  logic                 rdy_g_s, def_hit_s;

  // Slot order for the busy/ready/finish vectors is S0, S1, S2, S5.
  assign mvalid_s = {1'b0, ARVALID_M2, ARVALID_M1, ARVALID_M0};
  assign sready_s = {ARREADY_S5, ARREADY_S2, ARREADY_S1, ARREADY_S0};
  assign finish_s = {finish_S5, finish_S2, finish_S1, finish_S0};

  // Route the granted master's request fields
  always_comb begin
    case (grant_q)
      MST_M0: begin
        g_id_s = ARID_M0; g_addr_s = ARADDR_M0; g_len_s = ARLEN_M0;
        g_size_s = ARSIZE_M0; g_burst_s = ARBURST_M0;
      end
      MST_M1: begin
        g_id_s = ARID_M1; g_addr_s = ARADDR_M1; g_len_s = ARLEN_M1;
        g_size_s = ARSIZE_M1; g_burst_s = ARBURST_M1;
      end
      MST_M2: begin
        g_id_s = ARID_M2; g_addr_s = ARADDR_M2; g_len_s = ARLEN_M2;
        g_size_s = ARSIZE_M2; g_burst_s = ARBURST_M2;
      end
      default: begin
        g_id_s = {ID_BITS{1'b0}}; g_addr_s = {ADDR_BITS{1'b0}}; g_len_s = 4'd0;
        g_size_s = 3'd0; g_burst_s = 2'd0;
      end
    endcase
  end

  assign fwd_id_s = {2'b00, grant_q, g_id_s};
  assign slot_s   = sel_slot(sel_s);

  ar_addr_decoder u_dec (
    .addr_i (g_addr_s),
    .sel_o  (sel_s)
  );

  // Round-robin pick: first valid master starting at rr_q
  always_comb begin
    pick_s  = rr_q;
    found_s = 1'b0;
    cand_s  = rr_q;
    for (int k = 0; k < NUM_MST; k++) begin
      if (!found_s && mvalid_s[cand_s]) begin
        pick_s  = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
      cand_s = mst_inc(cand_s);
    end
  end

  // Output decode for the granted request; a busy target simply stalls
  always_comb begin
    slv_vld_s = 4'b0000;
    accept_s  = 4'b0000;
    rdy_g_s   = 1'b0;
    def_hit_s = 1'b0;
    if (state_q == AR_BUSY) begin
      if (sel_s == SEL_DEF) begin
        rdy_g_s   = 1'b1;
        def_hit_s = 1'b1;
      end else if (!busy_q[slot_s]) begin
        slv_vld_s[slot_s] = 1'b1;
        rdy_g_s           = sready_s[slot_s];
        accept_s[slot_s]  = sready_s[slot_s];
      end else begin
        rdy_g_s = 1'b0;
      end
    end else begin
      rdy_g_s = 1'b0;
    end
  end

  // Next-state: grant in IDLE, return to IDLE on handshake or default-slave hit
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    case (state_q)
      AR_IDLE: begin
        if (|mvalid_s) begin
          state_d = AR_BUSY;
          grant_d = pick_s;
        end else begin
          state_d = AR_IDLE;
        end
      end
      AR_BUSY: begin
        if (def_hit_s || (|accept_s)) begin
          state_d = AR_IDLE;
          rr_d    = mst_inc(grant_q);
        end else begin
          state_d = AR_BUSY;
        end
      end
      default: state_d = AR_IDLE;
    endcase
    busy_d = (busy_q & ~finish_s) | accept_s;
  end

  // State, grant, pointer and per-slave busy registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AR_IDLE;
      grant_q <= MST_M0;
      rr_q    <= MST_M0;
      busy_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
    end
  end

  assign ARREADY_M0 = rdy_g_s & (grant_q == MST_M0);
  assign ARREADY_M1 = rdy_g_s & (grant_q == MST_M1);
  assign ARREADY_M2 = rdy_g_s & (grant_q == MST_M2);

  assign getaddr_default = def_hit_s;
  assign master_signal   = def_hit_s & (grant_q == MST_M1);

  // Unselected slave ports carry all-zero fields.
  assign ARVALID_S0 = slv_vld_s[0];
  assign ARID_S0    = slv_vld_s[0] ? fwd_id_s  : {IDS_BITS{1'b0}};
  assign ARADDR_S0  = slv_vld_s[0] ? g_addr_s  : {ADDR_BITS{1'b0}};
  assign ARLEN_S0   = slv_vld_s[0] ? g_len_s   : 4'd0;
  assign ARSIZE_S0  = slv_vld_s[0] ? g_size_s  : 3'd0;
  assign ARBURST_S0 = slv_vld_s[0] ? g_burst_s : 2'd0;

  assign ARVALID_S1 = slv_vld_s[1];
  assign ARID_S1    = slv_vld_s[1] ? fwd_id_s  : {IDS_BITS{1'b0}};
  assign ARADDR_S1  = slv_vld_s[1] ? g_addr_s  : {ADDR_BITS{1'b0}};
  assign ARLEN_S1   = slv_vld_s[1] ? g_len_s   : 4'd0;
  assign ARSIZE_S1  = slv_vld_s[1] ? g_size_s  : 3'd0;
  assign ARBURST_S1 = slv_vld_s[1] ? g_burst_s : 2'd0;

  assign ARVALID_S2 = slv_vld_s[2];
  assign ARID_S2    = slv_vld_s[2] ? fwd_id_s  : {IDS_BITS{1'b0}};
  assign ARADDR_S2  = slv_vld_s[2] ? g_addr_s  : {ADDR_BITS{1'b0}};
  assign ARLEN_S2   = slv_vld_s[2] ? g_len_s   : 4'd0;
  assign ARSIZE_S2  = slv_vld_s[2] ? g_size_s  : 3'd0;
  assign ARBURST_S2 = slv_vld_s[2] ? g_burst_s : 2'd0;

  assign ARVALID_S5 = slv_vld_s[3];
  assign ARID_S5    = slv_vld_s[3] ? fwd_id_s  : {IDS_BITS{1'b0}};
  assign ARADDR_S5  = slv_vld_s[3] ? g_addr_s  : {ADDR_BITS{1'b0}};
  assign ARLEN_S5   = slv_vld_s[3] ? g_len_s   : 4'd0;
  assign ARSIZE_S5  = slv_vld_s[3] ? g_size_s  : 3'd0;
  assign ARBURST_S5 = slv_vld_s[3] ? g_burst_s : 2'd0;

endmodule
